// File: rtl/alu_pkg.sv
// Shared opcode encodings, stage FSM states and NZCV flag bit positions for the ALU stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'b0000,
    OpEor = 4'b0001,
    OpSub = 4'b0010,
    OpRsb = 4'b0011,
    OpAdd = 4'b0100,
    OpAdc = 4'b0101,
    OpSbc = 4'b0110,
    OpRsc = 4'b0111,
    OpTst = 4'b1000,
    OpTeq = 4'b1001,
    OpCmp = 4'b1010,
    OpCmn = 4'b1011,
    OpOrr = 4'b1100,
    OpMov = 4'b1101,
    OpBic = 4'b1110,
    OpMvn = 4'b1111
  } alu_op_e;

  typedef enum logic {
    StIdle,
    StMul
  } alu_state_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Compare/test ops: always set flags, never write Rd.
  function automatic logic is_test(alu_op_e op);
    return op inside {OpTst, OpTeq, OpCmp, OpCmn};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: WIDTH steps, low WIDTH bits of a*b + acc.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] step;

  // product is the value after this cycle's step, valid when done is high.
  assign step    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == '0);
  assign busy    = busy_q;
  assign product = step;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CntW'(WIDTH - 1);
      mcand_d  = a;
      mplier_d = b;
      prod_d   = acc;
    end else if (busy_q) begin
      prod_d   = step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: single-cycle data-processing ops, iterative MUL/MLA, NZCV flag register
// and a one-entry valid/ready output register.
module alu_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             is_mul,
  input  logic             set_flags,
  input  logic             cond_pass,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] acc,
  input  logic             shift_carry,
  input  logic [15:0]      tag_in,
  output logic [15:0]      tag_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [3:0]       flags
);

  alu_state_e       state_q, state_d;
  alu_op_e          op;
  logic             accept, mul_sel, mul_accept, alu_accept;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product, mul_acc;

  logic             out_valid_q, out_valid_d, wr_en_q, wr_en_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [15:0]      tag_q, tag_d, m_tag_q, m_tag_d;
  logic [3:0]       flags_q, flags_d;
  logic             m_wr_q, m_wr_d, m_setf_q, m_setf_d;

  logic             arith, cin, alu_c, alu_v;
  logic [WIDTH-1:0] x, y, logic_res, alu_res;
  logic [WIDTH:0]   sum;

  assign op         = alu_op_e'(opcode);
  assign accept     = in_valid && in_ready;
  assign mul_sel    = MUL_EN && is_mul;
  assign mul_accept = accept && mul_sel;
  assign alu_accept = accept && !mul_sel;
  assign mul_acc    = opcode[0] ? acc : '0;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_accept),
    .a       (rn),
    .b       (op2),
    .acc     (mul_acc),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mul_accept) state_d = StMul;
      StMul:   if (mul_done || !mul_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  end

  // Subtracts are x + ~y + cin so C comes out as NOT borrow.
  always_comb begin
    arith     = 1'b1;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    logic_res = '0;
    unique case (op)
      OpAnd, OpTst: begin arith = 1'b0; logic_res = rn & op2;  end
      OpEor, OpTeq: begin arith = 1'b0; logic_res = rn ^ op2;  end
      OpOrr:        begin arith = 1'b0; logic_res = rn | op2;  end
      OpMov:        begin arith = 1'b0; logic_res = op2;       end
      OpBic:        begin arith = 1'b0; logic_res = rn & ~op2; end
      OpMvn:        begin arith = 1'b0; logic_res = ~op2;      end
      OpSub, OpCmp: begin x = rn;  y = ~op2; cin = 1'b1;           end
      OpRsb:        begin x = op2; y = ~rn;  cin = 1'b1;           end
      OpAdd, OpCmn: begin x = rn;  y = op2;  cin = 1'b0;           end
      OpAdc:        begin x = rn;  y = op2;  cin = flags_q[FlagC]; end
      OpSbc:        begin x = rn;  y = ~op2; cin = flags_q[FlagC]; end
      OpRsc:        begin x = op2; y = ~rn;  cin = flags_q[FlagC]; end
      default:      arith = 1'b0;
    endcase
    sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    alu_res = arith ? sum[WIDTH-1:0] : logic_res;
    alu_c   = arith ? sum[WIDTH] : shift_carry;
    alu_v   = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (alu_res[WIDTH-1] != x[WIDTH-1]))
                    : flags_q[FlagV];
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    wr_en_d     = wr_en_q;
    tag_d       = tag_q;
    flags_d     = flags_q;
    m_tag_d     = m_tag_q;
    m_wr_d      = m_wr_q;
    m_setf_d    = m_setf_q;
    if (alu_accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      wr_en_d     = cond_pass && !is_test(op);
      tag_d       = tag_in;
      if (cond_pass && (set_flags || is_test(op))) begin
        flags_d[FlagN] = alu_res[WIDTH-1];
        flags_d[FlagZ] = (alu_res == '0);
        flags_d[FlagC] = alu_c;
        flags_d[FlagV] = alu_v;
      end
    end
    if (mul_accept) begin
      m_tag_d  = tag_in;
      m_wr_d   = cond_pass;
      m_setf_d = cond_pass && set_flags;
    end
    if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_product;
      wr_en_d     = m_wr_q;
      tag_d       = m_tag_q;
      if (m_setf_q) begin
        flags_d[FlagN] = mul_product[WIDTH-1];
        flags_d[FlagZ] = (mul_product == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wr_en_q     <= 1'b0;
      tag_q       <= '0;
      flags_q     <= '0;
      m_tag_q     <= '0;
      m_wr_q      <= 1'b0;
      m_setf_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wr_en_q     <= wr_en_d;
      tag_q       <= tag_d;
      flags_q     <= flags_d;
      m_tag_q     <= m_tag_d;
      m_wr_q      <= m_wr_d;
      m_setf_q    <= m_setf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wr_en     = wr_en_q;
  assign tag_out   = tag_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage at WIDTH=16: directed ops push expected beats, a monitor
// pops and compares every output handshake.
module tb_alu_stage;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, is_mul, set_flags, cond_pass, shift_carry;
  logic [3:0]    opcode;
  logic [W-1:0]  rn, op2, acc, result;
  logic [15:0]   tag_in, tag_out;
  logic          out_valid, out_ready, wr_en;
  logic [3:0]    flags;

  typedef struct packed {
    logic [15:0] res;
    logic        wr;
    logic [3:0]  fl;
    logic [15:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beats    = 0;
  int   beats0;
  int   waits;

  alu_stage #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .is_mul      (is_mul),
    .set_flags   (set_flags),
    .cond_pass   (cond_pass),
    .rn          (rn),
    .op2         (op2),
    .acc         (acc),
    .shift_carry (shift_carry),
    .tag_in      (tag_in),
    .tag_out     (tag_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .wr_en       (wr_en),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic m, input logic s, input logic cp,
                       input logic sc, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] t, input logic [15:0] er,
                       input logic ew, input logic [3:0] ef, output int nwait);
    opcode = op; is_mul = m; set_flags = s; cond_pass = cp; shift_carry = sc;
    rn = a; op2 = b; acc = c; tag_in = t; in_valid = 1'b1;
    nwait = 0;
    @(negedge clk);
    while (!in_ready && nwait < 100) begin
      nwait++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tag %h never accepted, required acceptance", t);
    end else begin
      @(posedge clk);
      exp_q.push_back('{res: er, wr: ew, fl: ef, tag: t});
    end
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got result %h tag %h, required no beat", result, tag_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 32'(result), 32'(mon_e.res));
        check("wr_en", 32'(wr_en), 32'(mon_e.wr));
        check("flags", 32'(flags), 32'(mon_e.fl));
        check("tag_out", 32'(tag_out), 32'(mon_e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = 4'h0; is_mul = 1'b0;
    set_flags = 1'b0; cond_pass = 1'b1; shift_carry = 1'b0;
    rn = '0; op2 = '0; acc = '0; tag_in = '0;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_tag", 32'(tag_out), 32'h0);
    reset = 1'b0;
    check("rdy_after_rst", 32'(in_ready), 32'h1);

    issue(4'b0100, 0, 1, 1, 0, 16'h7FFF, 16'h0001, 16'h0, 16'h0001, 16'h8000, 1, 4'b1001, waits);
    check("add_latency_valid", 32'(out_valid), 32'h1);
    check("add_latency_result", 32'(result), 32'h8000);
    issue(4'b1010, 0, 0, 1, 0, 16'h0005, 16'h0005, 16'h0, 16'h0002, 16'h0000, 0, 4'b0110, waits);
    issue(4'b0101, 0, 0, 1, 0, 16'h0001, 16'h0001, 16'h0, 16'h0003, 16'h0003, 1, 4'b0110, waits);

    // MLA: beat exactly 16 edges after acceptance, stage busy meanwhile
    issue(4'b0001, 1, 0, 1, 0, 16'h0012, 16'h0034, 16'h0001, 16'h0004, 16'h03A9, 1, 4'b0110,
          waits);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        check("mla_busy_valid", 32'(out_valid), 32'h0);
        check("mla_busy_ready", 32'(in_ready), 32'h0);
      end else begin
        check("mla_done_valid", 32'(out_valid), 32'h1);
      end
    end
    issue(4'b0000, 1, 1, 1, 0, 16'h0101, 16'h00FF, 16'h5555, 16'h0005, 16'hFFFF, 1, 4'b1010,
          waits);
    repeat (20) tick();

    out_ready = 1'b0;
    issue(4'b0010, 0, 1, 1, 0, 16'h0010, 16'h0003, 16'h0, 16'h0006, 16'h000D, 1, 4'b0010, waits);
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_result", 32'(result), 32'h000D);
      check("stall_flags", 32'(flags), 32'h2);
      check("stall_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    issue(4'b1100, 0, 1, 1, 0, 16'h00F0, 16'h000F, 16'h0, 16'h0007, 16'h00FF, 1, 4'b0000, waits);
    check("release_accept_same_edge", 32'(waits), 32'h0);

    issue(4'b0010, 0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0, 16'h0008, 16'hFFFF, 0, 4'b0000, waits);
    issue(4'b0011, 0, 1, 1, 0, 16'h0001, 16'h0000, 16'h0, 16'h0009, 16'hFFFF, 1, 4'b1000, waits);
    issue(4'b0110, 0, 1, 1, 0, 16'h0005, 16'h0003, 16'h0, 16'h000A, 16'h0001, 1, 4'b0010, waits);
    issue(4'b0111, 0, 1, 1, 0, 16'h0002, 16'h0007, 16'h0, 16'h000B, 16'h0005, 1, 4'b0010, waits);
    issue(4'b1111, 0, 1, 1, 0, 16'h1234, 16'h0000, 16'h0, 16'h000C, 16'hFFFF, 1, 4'b1000, waits);
    issue(4'b1001, 0, 0, 1, 1, 16'hAAAA, 16'hAAAA, 16'h0, 16'h000D, 16'h0000, 0, 4'b0110, waits);
    issue(4'b1011, 0, 0, 1, 0, 16'h8000, 16'h8000, 16'h0, 16'h000E, 16'h0000, 0, 4'b0111, waits);
    issue(4'b1110, 0, 0, 1, 1, 16'h0FF0, 16'h00FF, 16'h0, 16'h000F, 16'h0F00, 1, 4'b0111, waits);
    issue(4'b0000, 0, 1, 1, 0, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0010, 16'h0000, 1, 4'b0101, waits);
    issue(4'b0001, 0, 1, 1, 1, 16'h8000, 16'h0001, 16'h0, 16'h0011, 16'h8001, 1, 4'b1011, waits);
    issue(4'b1101, 0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0, 16'h0012, 16'h1234, 1, 4'b1011, waits);
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the 7th multiply cycle aborts it with no beat
    issue(4'b0000, 1, 1, 1, 0, 16'h0003, 16'h0003, 16'h0, 16'h0013, 16'h0009, 1, 4'b0011, waits);
    repeat (6) tick();
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'h0);
    check("abort_flags", 32'(flags), 32'h0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_wr_en", 32'(wr_en), 32'h0);
    check("abort_tag", 32'(tag_out), 32'h0);
    exp_q.delete();
    beats0 = beats;
    tick();
    reset = 1'b0;
    check("abort_rdy_after_rst", 32'(in_ready), 32'h1);
    repeat (25) tick();
    check("abort_no_beat", 32'(beats), 32'(beats0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 Parameter MUL_EN, default 1, 1 enables multiply/multiply-accumulate ops.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  stage accepts operation this cycle.
REQ-007 opcode  input  4  data-processing op: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ADC 0101, SBC 0110, RSC 0111, TST 1000, TEQ 1001, CMP 1010, CMN 1011, ORR 1100, MOV 1101, BIC 1110, MVN 1111.
REQ-008 is_mul  input  1  multiply op; opcode[0]=1 selects MLA (rn*op2+acc), else MUL.
REQ-009 set_flags  input  1  S bit.
REQ-010 cond_pass  input  1  condition check passed upstream.
REQ-011 rn, op2, acc  input  WIDTH each  first operand, shifted second operand, MLA addend.
REQ-012 shift_carry  input  1  shifter carry-out.
REQ-013 tag_in / tag_out  input/output  16  instruction word, passed through unmodified.
REQ-014 out_valid  output  1  result held.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 result  output  WIDTH  computed value.
REQ-017 wr_en  output  1  result must be written to Rd.
REQ-018 flags  output  4  architectural NZCV, bits [3:0]=N,Z,C,V.

Function
REQ-019 Acceptance SHALL occur on a rising edge with in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-020 Non-multiply ops SHALL present result/out_valid on the edge of acceptance (latency 1).
REQ-021 Multiply SHALL use an iterative shift-add over WIDTH cycles: states IDLE -> MUL (WIDTH cycles, counter WIDTH-1..0) -> IDLE; out_valid asserts on the edge ending the last MUL cycle; result = low WIDTH bits.
REQ-022 With MUL_EN=0, is_mul SHALL be ignored and the op treated per opcode.
REQ-023 out_valid && !out_ready SHALL hold result, wr_en, tag_out, flags stable; a new result may load on the same edge the old one is consumed.
REQ-024 ADD/ADC/CMN: C = unsigned carry-out of WIDTH-bit sum; SUB/SBC/CMP/RSB/RSC: C = NOT borrow; ADC adds C, SBC/RSC subtract NOT C, using the flag register value at acceptance.
REQ-025 V for arithmetic ops SHALL be signed overflow: operands of equal effective sign producing result of opposite sign; V unchanged for logical ops.
REQ-026 Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shift_carry.
REQ-027 N = result[WIDTH-1], Z = (result==0) for all ops; multiply updates N,Z only, C,V unchanged.
REQ-028 Flags SHALL update only when set_flags && cond_pass, on the edge result becomes valid; TST/TEQ/CMP/CMN update flags regardless of set_flags.
REQ-029 wr_en = cond_pass && op not in {TST,TEQ,CMP,CMN}.
REQ-030 cond_pass=0 SHALL still produce an output beat (tag forwarded) with wr_en=0, flags unchanged.
REQ-031 Back-to-back ADC after a flag-setting op SHALL observe the just-updated C.

Reset
REQ-032 reset SHALL immediately force state=IDLE, out_valid=0, wr_en=0, result=0, tag_out=0, flags=0000, multiply counter/partials=0, aborting any multiply in progress with no output beat.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-034 Package alu_pkg SHALL hold opcode constants, state enum, and NZCV bit indices.
REQ-035 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands, busy, done, product).

Verification (WIDTH=16)
REQ-036 ADD rn=0x7FFF op2=0x0001 S=1 -> result 0x8000, NZCV=1001, latency 1.
REQ-037 CMP rn=0x0005 op2=0x0005 -> wr_en=0, NZCV=0110; next ADC rn=1 op2=1 -> result 0x0003.
REQ-038 MLA rn=0x0012 op2=0x0034 acc=0x0001 -> result 0x03A9 exactly 16 cycles after acceptance, in_ready=0 throughout.
REQ-039 out_ready=0 for 3 cycles with result pending -> result/flags stable, in_ready=0; release -> next op accepted same edge.
REQ-040 cond_pass=0 SUB S=1 -> beat with wr_en=0, flags unchanged.
REQ-041 reset asserted mid-multiply (cycle 7) -> out_valid=0 immediately, no beat, flags=0000.
